// File: rtl/subtractor_time2_if.sv
// subtractor_time2 control/status bundle.
// Master drives load/in/en/auto; slave returns count and flags.
interface subtractor_time2_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] in;
    logic             en;
    logic             auto;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, in, en, auto,
        input  q, tc, busy, done
    );

    modport slave (
        input  load, in, en, auto,
        output q, tc, busy, done
    );
endinterface

// File: rtl/subtractor_time2.sv
// Loadable down-counter with one-cycle terminal-count pulse.
// One-shot parks in DONE; auto mode reloads the last loaded value.
module subtractor_time2 #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               clr,
    subtractor_time2_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rl;
    logic             tc;

    // Count state, reload value and tc pulse; load overrides counting.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            q     <= '0;
            rl    <= '0;
            tc    <= 1'b0;
        end else if (bus.load) begin
            q     <= bus.in;
            rl    <= bus.in;
            tc    <= 1'b0;
            state <= (bus.in != '0) ? RUN : IDLE;
        end else begin
            tc <= 1'b0;
            unique case (state)
                IDLE: begin
                end
                RUN: begin
                    if (bus.en) begin
                        if (q > ONE) begin
                            q <= q - ONE;
                        end else if (q == ONE) begin
                            q  <= '0;
                            tc <= 1'b1;
                            if (!bus.auto) begin
                                state <= DONE;
                            end
                        end else begin
                            // Only reached in auto mode: restart period.
                            q <= rl;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q;
    assign bus.tc   = tc;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_subtractor_time2.sv
// Bench for subtractor_time2: directed scenarios plus random
// stimulus against a behavioural down-counter model.
module tb_subtractor_time2;
    localparam int W = 4;

    logic clk;
    logic clr;
    int   ncmp;
    int   nfail;

    // reference model: mode 0=idle 1=run 2=done
    logic [W-1:0] mq;
    logic [W-1:0] mrl;
    logic         mtc;
    int           mmode;

    subtractor_time2_if #(.WIDTH(W)) bus ();

    subtractor_time2 #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq    = '0;
        mrl   = '0;
        mtc   = 1'b0;
        mmode = 0;
    endtask

    // advance model by one edge using the inputs presented now
    task automatic model_step();
        int v;
        if (clr) begin
            model_reset();
        end else if (bus.load) begin
            mq    = bus.in;
            mrl   = bus.in;
            mtc   = 1'b0;
            mmode = (bus.in == 0) ? 0 : 1;
        end else begin
            mtc = 1'b0;
            if (mmode == 1 && bus.en) begin
                v = int'(mq);
                if (v == 0) begin
                    mq = mrl;
                end else begin
                    mq = W'(v - 1);
                    if (v == 1) begin
                        mtc = 1'b1;
                        if (!bus.auto) mmode = 2;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [W-1:0] v,
                         input logic e, input logic a);
        bus.load = ld;
        bus.in   = v;
        bus.en   = e;
        bus.auto = a;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        #2;
        ncmp++;
        if ({bus.q, bus.tc, bus.busy, bus.done} !== {W'(0), 3'b000}) begin
            nfail++;
            $display("FAIL reset_init: got q=%0d tc=%b busy=%b done=%b want 0/0/0/0",
                     bus.q, bus.tc, bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        drive(1'b1, W'(5), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        ncmp++;
        if (bus.q !== W'(5) || bus.busy !== 1'b1) begin
            nfail++;
            $display("FAIL reset_pre: got q=%0d busy=%b want 5/1",
                     bus.q, bus.busy);
        end
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        ncmp++;
        if ({bus.q, bus.tc, bus.busy, bus.done} !== {W'(0), 3'b000}) begin
            nfail++;
            $display("FAIL reset_async: got q=%0d tc=%b busy=%b done=%b want 0/0/0/0",
                     bus.q, bus.tc, bus.busy, bus.done);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [W-1:0] exp_q [4];
        exp_q = '{W'(3), W'(2), W'(1), W'(0)};
        drive(1'b1, W'(3), 1'b1, 1'b0);
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 14; i++) begin
            logic [W-1:0] eq;
            logic etc;
            eq  = (i < 4) ? exp_q[i] : W'(0);
            etc = (i == 3);
            ncmp++;
            if (bus.q !== eq || bus.tc !== etc || bus.done !== (i >= 3)
                || bus.busy !== (i < 3) || bus.q !== mq) begin
                nfail++;
                $display("FAIL oneshot[%0d]: got q=%0d tc=%b busy=%b done=%b want q=%0d tc=%b",
                         i, bus.q, bus.tc, bus.busy, bus.done, eq, etc);
            end
            tick();
        end
    endtask

    task automatic test_auto();
        int ntc;
        ntc = 0;
        drive(1'b1, W'(2), 1'b1, 1'b1);
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] eq;
            eq = W'(2 - (i % 3));
            if (bus.tc) ntc++;
            ncmp++;
            if (bus.q !== eq || bus.tc !== (i % 3 == 2) || bus.busy !== 1'b1
                || bus.done !== 1'b0) begin
                nfail++;
                $display("FAIL auto[%0d]: got q=%0d tc=%b busy=%b want q=%0d tc=%b",
                         i, bus.q, bus.tc, bus.busy, eq, (i % 3 == 2));
            end
            tick();
        end
        ncmp++;
        if (ntc !== 4) begin
            nfail++;
            $display("FAIL auto_tc_count: got %0d want 4", ntc);
        end
    endtask

    task automatic test_enable();
        logic         en_pat [7];
        logic [W-1:0] exp_q  [8];
        en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_q  = '{W'(4), W'(3), W'(3), W'(3), W'(2), W'(1), W'(1), W'(0)};
        drive(1'b1, W'(4), 1'b0, 1'b0);
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ncmp++;
            if (bus.q !== exp_q[i] || bus.tc !== (i == 7)) begin
                nfail++;
                $display("FAIL enable[%0d]: got q=%0d tc=%b want q=%0d tc=%b",
                         i, bus.q, bus.tc, exp_q[i], (i == 7));
            end
            if (i < 7) begin
                bus.en = en_pat[i];
                tick();
            end
        end
        bus.en = 1'b0;
        tick();
        ncmp++;
        if (bus.tc !== 1'b0 || bus.done !== 1'b1) begin
            nfail++;
            $display("FAIL enable_after: got tc=%b done=%b want 0/1",
                     bus.tc, bus.done);
        end
    endtask

    task automatic test_load_collision();
        drive(1'b1, W'(2), 1'b1, 1'b0);
        tick();
        bus.load = 1'b0;
        tick();
        ncmp++;
        if (bus.q !== W'(1)) begin
            nfail++;
            $display("FAIL coll_setup: got q=%0d want 1", bus.q);
        end
        drive(1'b1, W'(7), 1'b1, 1'b0);
        tick();
        ncmp++;
        if (bus.q !== W'(7) || bus.tc !== 1'b0 || bus.busy !== 1'b1
            || bus.done !== 1'b0) begin
            nfail++;
            $display("FAIL coll_load7: got q=%0d tc=%b busy=%b done=%b want 7/0/1/0",
                     bus.q, bus.tc, bus.busy, bus.done);
        end
        drive(1'b1, W'(0), 1'b1, 1'b0);
        tick();
        ncmp++;
        if (bus.q !== W'(0) || bus.tc !== 1'b0 || bus.busy !== 1'b0
            || bus.done !== 1'b0) begin
            nfail++;
            $display("FAIL coll_load0: got q=%0d tc=%b busy=%b done=%b want 0/0/0/0",
                     bus.q, bus.tc, bus.busy, bus.done);
        end
        bus.load = 1'b0;
        tick();
        ncmp++;
        if (bus.q !== W'(0) || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
            nfail++;
            $display("FAIL idle_hold: got q=%0d busy=%b tc=%b want 0/0/0",
                     bus.q, bus.busy, bus.tc);
        end
    endtask

    task automatic test_width();
        int ntc;
        ntc = 0;
        drive(1'b1, W'(15), 1'b1, 1'b0);
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] eq;
            eq = (i < 15) ? W'(15 - i) : W'(0);
            if (bus.tc) ntc++;
            ncmp++;
            if (bus.q !== eq) begin
                nfail++;
                $display("FAIL width[%0d]: got q=%0d want %0d", i, bus.q, eq);
            end
            tick();
        end
        ncmp++;
        if (ntc !== 1) begin
            nfail++;
            $display("FAIL width_tc_count: got %0d want 1", ntc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), W'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom));
            clr = ($urandom_range(0, 63) == 0);
            tick();
            ncmp++;
            if ({bus.q, bus.tc, bus.busy, bus.done}
                !== {mq, mtc, (mmode == 1), (mmode == 2)}) begin
                nfail++;
                $display("FAIL random[%0d]: got q=%0d tc=%b busy=%b done=%b want q=%0d tc=%b busy=%b done=%b",
                         i, bus.q, bus.tc, bus.busy, bus.done,
                         mq, mtc, (mmode == 1), (mmode == 2));
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        test_reset();
        test_oneshot();
        test_auto();
        test_enable();
        test_load_collision();
        test_width();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
